main_memory: RTL and testbench

Backing main memory for the 4-way set-associative cache. It sits directly downstream of the cache and serves line fills on a miss and posted write-backs of dirty victims. Reads pass through a fixed-latency request/response channel. Writes are absorbed by a single-entry write buffer that drains to the array in the background and forwards its data to matching reads.

---
 rtl/main_mem_pkg.sv | 31 +++
 rtl/main_memory_write_buffer.sv | 78 +++++++
 rtl/main_memory.sv | 171 +++++++++++++++++
 tb/tb_main_memory.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// ---------------------------------------------------------------------------
// main_mem_pkg
// Shared definitions for the cache backing memory: address/data geometry,
// the read-channel state encoding and address field helpers that the cache
// uses to split a word address into {tag, set}.
// ---------------------------------------------------------------------------
package main_mem_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 3;
   localparam int TAG_W  = 3;
   localparam int SET_W  = 2;

   // Read channel states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Upper address bits: cache tag
   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   // Lower address bits: cache set index
   function automatic logic [SET_W-1:0] set_of(input logic [ADDR_W-1:0] addr);
      return addr[SET_W-1:0];
   endfunction

endpackage

// File: rtl/main_memory_write_buffer.sv
// ---------------------------------------------------------------------------
// write_buffer
// Single-entry posted write buffer. Holds one write-back until its drain
// counter expires, then raises o_commit for exactly one cycle so the owner
// can write the array. Also answers "does this read address match the
// buffered entry" for store-to-load forwarding.
//
// Ports
//   clock, reset  : clock, synchronous active-high reset
//   i_load        : capture i_addr/i_data (only asserted while empty)
//   i_addr/i_data : write-back address and data
//   i_rd_addr     : address of the read being accepted this cycle
//   o_full        : entry occupied
//   o_addr/o_data : buffered entry
//   o_hit         : entry occupied and matches i_rd_addr
//   o_commit      : entry drains to the array on this edge
// ---------------------------------------------------------------------------
module write_buffer #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 3,
   parameter int LATENCY = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_hit,
   output logic              o_commit
);
   import main_mem_pkg::*;

   localparam int CNT_W = 4;
   // Loaded with LATENCY-1 so the commit edge lands LATENCY edges after
   // the accepting edge (the load edge itself counts as the first).
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(LATENCY - 1);

   logic              r_full;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_commit;

   assign w_commit = r_full && (r_cnt == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_full <= 1'b0;
         r_cnt  <= '0;
         r_addr <= '0;
         r_data <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_cnt  <= DRAIN_LOAD;
         r_addr <= i_addr;
         r_data <= i_data;
      end else if (r_full) begin
         if (w_commit) begin
            r_full <= 1'b0;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign o_full   = r_full;
   assign o_addr   = r_addr;
   assign o_data   = r_data;
   // A read on the commit edge still sees r_full and forwards; the data is
   // the same value the array receives on that edge.
   assign o_hit    = r_full && (r_addr == i_rd_addr);
   assign o_commit = w_commit;

endmodule

// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
// Backing store for the 4-way set-associative cache. Fill reads go through
// a fixed-latency request/response channel; dirty write-backs are posted
// into a single-entry write buffer that drains in the background and
// forwards its data to matching reads.
//
// Ports
//   clock       : sole clock, rising edge
//   reset       : synchronous active-high reset (also reloads the array)
//   req_valid   : request present
//   req_ready   : request accepted when req_valid && req_ready at an edge
//   req_write   : 1 = write-back, 0 = fill read
//   req_addr    : word address {tag, set}
//   req_wdata   : write-back data
//   resp_valid  : one-cycle pulse, resp_data valid
//   resp_data   : read data, held until the next response
//   wb_pending  : write buffer occupied
// ---------------------------------------------------------------------------
module main_memory #(
   parameter int ADDR_W  = main_mem_pkg::ADDR_W,
   parameter int DATA_W  = main_mem_pkg::DATA_W,
   parameter int LATENCY = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              wb_pending
);
   import main_mem_pkg::*;

   localparam int CNT_W = 4;
   localparam int DEPTH = 1 << ADDR_W;
   // The response cycle itself accounts for one cycle of latency, so a
   // non-forwarded read waits LATENCY-1 cycles in WAIT; the counter counts
   // down to 0 inclusive, hence the -2. LATENCY = 1 skips WAIT entirely.
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
   localparam bit               RD_FAST = (LATENCY == 1);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_hold;
   logic [DATA_W-1:0] r_resp_data;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic              w_rd_accept;
   logic              w_wr_accept;
   logic              w_direct;
   logic [DATA_W-1:0] w_rd_word;

   logic              w_wb_full;
   logic              w_wb_hit;
   logic              w_wb_commit;
   logic [ADDR_W-1:0] w_wb_addr;
   logic [DATA_W-1:0] w_wb_data;

   assign w_accept    = req_valid && req_ready;
   assign w_rd_accept = w_accept && !req_write;
   assign w_wr_accept = w_accept && req_write;

   // Read data is fixed at acceptance; a later drain cannot change it.
   assign w_rd_word = w_wb_hit ? w_wb_data : r_mem[req_addr];
   // Forwarded reads and LATENCY = 1 reads go straight to RESP.
   assign w_direct  = w_wb_hit || RD_FAST;

   write_buffer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY)
   ) u_wb (
      .clock     (clock),
      .reset     (reset),
      .i_load    (w_wr_accept),
      .i_addr    (req_addr),
      .i_data    (req_wdata),
      .i_rd_addr (req_addr),
      .o_full    (w_wb_full),
      .o_addr    (w_wb_addr),
      .o_data    (w_wb_data),
      .o_hit     (w_wb_hit),
      .o_commit  (w_wb_commit)
   );

   // ---- read FSM: state register ----
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---- read FSM: next state ----
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_rd_accept) begin
               w_next = w_direct ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_next = RESP;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ---- read FSM: outputs ----
   // req_ready looks at req_write combinationally so a full write buffer
   // never stalls a fill read.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE:    req_ready  = !req_write || !w_wb_full;
         RESP:    resp_valid = 1'b1;
         default: begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
         end
      endcase
   end

   // Latency counter, captured read word and the held response register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= '0;
         r_hold      <= '0;
         r_resp_data <= '0;
      end else if (w_rd_accept) begin
         r_cnt  <= RD_LOAD;
         r_hold <= w_rd_word;
         if (w_direct) begin
            r_resp_data <= w_rd_word;
         end
      end else if (r_state == WAIT) begin
         if (r_cnt == '0) begin
            r_resp_data <= r_hold;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   // Array: reset pattern makes an unwritten word read back its own tag.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= DATA_W'(i >> SET_W);
         end
      end else if (w_wb_commit) begin
         r_mem[w_wb_addr] <= w_wb_data;
      end
   end

   assign resp_data  = r_resp_data;
   assign wb_pending = w_wb_full;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

   localparam int AW  = 5;
   localparam int DW  = 3;
   localparam int LAT = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic          wb_pending;

   main_memory #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .LATENCY (LAT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .wb_pending (wb_pending)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model. Time is counted in edges since the last reset edge;
   // "interval k" is the clock period that follows edge k.
   //   memory      : last value written per address (reads always see it,
   //                 whether through forwarding or the array)
   //   idle_from   : first edge at which a new request can be accepted
   //   resp_int    : interval in which resp_valid is expected
   //   wb_until    : edge at which the posted write leaves the buffer
   logic [DW-1:0] m_mem [32];
   int            cyc;
   int            m_idle_from;
   int            m_resp_int;
   int            m_wb_until;
   logic [AW-1:0] m_wb_addr;
   logic [DW-1:0] m_held;
   logic [DW-1:0] m_pend;
   bit            last_acc;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = DW'(i >> 2);
      cyc         = 0;
      m_idle_from = 0;
      m_resp_int  = -1;
      m_wb_until  = 0;
      m_wb_addr   = '0;
      m_held      = '0;
      m_pend      = '0;
   endfunction

   // One clock: drive at the falling edge, check outputs, then apply the
   // effect of the rising edge to the model.
   task automatic step(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit exp_ready;
      bit acc;
      bit hit;
      int lat;
      @(negedge clock);
      reset     = 1'b0;
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      #1;
      exp_ready = (cyc + 1 >= m_idle_from) && (!w || cyc >= m_wb_until);
      check("req_ready", req_ready, exp_ready);
      check("resp_valid", resp_valid, (cyc == m_resp_int));
      if (cyc == m_resp_int) m_held = m_pend;
      check("resp_data", resp_data, m_held);
      check("wb_pending", wb_pending, (cyc < m_wb_until));
      acc = v && exp_ready;
      @(posedge clock);
      cyc++;
      last_acc = acc;
      if (acc) begin
         if (w) begin
            m_mem[a]   = d;
            m_wb_until = cyc + LAT;
            m_wb_addr  = a;
         end else begin
            hit         = (cyc - 1 < m_wb_until) && (m_wb_addr == a);
            lat         = hit ? 1 : LAT;
            m_pend      = m_mem[a];
            m_resp_int  = cyc + lat - 1;
            m_idle_from = cyc + lat + 1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      @(posedge clock);
      model_reset();
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_valid", resp_valid, 0);
      check("rst_data", resp_data, 0);
      check("rst_wbp", wb_pending, 0);
   endtask

   // Issue a read (retrying while not ready) and check the response it gets.
   task automatic read_check(input string tag, input logic [AW-1:0] a,
                             input logic [DW-1:0] exp, input bit fwd);
      int n;
      n = 0;
      do begin
         step(1'b1, 1'b0, a, '0);
         n++;
      end while (!last_acc && n < 20);
      check({tag, "_acc"}, last_acc, 1);
      repeat ((fwd ? 1 : LAT) - 1) step(1'b0, 1'b0, '0, '0);
      #1;
      check({tag, "_valid"}, resp_valid, 1);
      check({tag, "_data"}, resp_data, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w_edge;
      int n;
      logic [AW-1:0] recent;
      bit v, w;
      logic [AW-1:0] a;

      // Plain fill read returns its own tag after LATENCY cycles
      do_reset();
      step(1'b1, 1'b0, 5'b011_01, '0);
      #1;
      check("tp1_busy", req_ready, 0);
      idle(LAT - 1);
      #1;
      check("tp1_valid", resp_valid, 1);
      check("tp1_data", resp_data, 3'b011);
      idle(2);

      // Read right behind a write to the same address is forwarded
      do_reset();
      step(1'b1, 1'b1, 5'b000_01, 3'b111);
      read_check("tp2", 5'b000_01, 3'b111, 1'b1);
      check("tp2_wbp", wb_pending, 1);
      idle(4);

      // Same write, read after the drain: served from the array
      do_reset();
      step(1'b1, 1'b1, 5'b000_01, 3'b111);
      idle(4);
      #1;
      check("tp3_wbp", wb_pending, 0);
      read_check("tp3", 5'b000_01, 3'b111, 1'b0);
      idle(2);

      // Back-to-back writes: second waits for the drain
      do_reset();
      step(1'b1, 1'b1, 5'b010_10, 3'b101);
      w_edge = cyc;
      #1;
      check("tp4_blocked", req_ready, 0);
      n = 0;
      do begin
         step(1'b1, 1'b1, 5'b101_01, 3'b010);
         n++;
      end while (!last_acc && n < 20);
      check("tp4_accept_edge", 32'(cyc), 32'(w_edge + LAT + 1));
      idle(LAT + 1);
      read_check("tp4a", 5'b010_10, 3'b101, 1'b0);
      read_check("tp4b", 5'b101_01, 3'b010, 1'b0);
      idle(2);

      // Unrelated read while the buffer drains
      do_reset();
      step(1'b1, 1'b1, 5'b001_10, 3'b010);
      read_check("tp5", 5'b100_11, 3'b100, 1'b0);
      #1;
      check("tp5_drained", wb_pending, 0);
      read_check("tp5w", 5'b001_10, 3'b010, 1'b0);
      idle(2);

      // Reset during WAIT drops the read and restores the array
      do_reset();
      step(1'b1, 1'b1, 5'b111_00, 3'b001);
      idle(4);
      read_check("tp6a", 5'b111_00, 3'b001, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 5'b010_00, '0);
      do_reset();
      idle(LAT + 2);
      read_check("tp6b", 5'b111_00, 3'b111, 1'b0);
      // A write still in the buffer is lost on reset
      idle(1);
      step(1'b1, 1'b1, 5'b110_11, 3'b000);
      do_reset();
      read_check("tp6c", 5'b110_11, 3'b110, 1'b0);
      idle(2);

      // Randomised traffic with occasional resets
      recent = '0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            v = ($urandom_range(0, 9) < 6);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 2) == 0) ? recent : AW'($urandom);
            step(v, w, a, DW'($urandom));
            if (last_acc && w) recent = a;
         end
      end
      idle(LAT + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
